pwm_bank_io: RTL and testbench
==============================

Name: pwm_bank_io

Overview:
- Memory-mapped, parametrised N-channel PWM peripheral; successor to the fixed per-motor/per-RGB PWM instances in the rover top level.
- Sits on the data-bus IO space behind the CPU and owns its own register file: enable mask, per-channel duty, sticky status.
- Adds what the fixed PWM instances lack: duty updates only at period boundaries (glitch-free), duty saturation, clear-on-read status, and bus error on unmapped access.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz.
- PWM_FREQ, 500, PWM frequency in Hz; PERIOD_CNT = CLK_FREQ/PWM_FREQ, must be >= 2.
- CHANNELS, 4, number of PWM outputs, 1..16.
- WL, 32, bus data width.
- ADDR_WL, 5, word-address width of the register window.
- DEADTIME_CYCLES, 8, guard cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  bus command strobe; always accepted, no ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WL  word index.
- cmd_wdata  in  WL  write data.
- rsp_valid  out  1  read response strobe.
- rsp_error  out  1  unmapped access flag, qualified by rsp_valid.
- rsp_data  out  WL  read data.
- pwm_o  out  CHANNELS  PWM outputs, registered.
- period_tick  out  1  one-cycle pulse at each period wrap.

Behaviour:
- Reset (async assert, sync release) sets all of the following to 0:
  - pwm_o, rsp_valid, rsp_error, rsp_data, period_tick;
  - period counter, CTRL, STATUS;
  - all pending and active duty values.
- Register map (word index):
  - 0 CTRL: bits [CHANNELS-1:0] channel enable, read/write, upper bits read as 0.
  - 1 STATUS: bit0 = wrap-seen, sticky; set on each period wrap; cleared by a read (the read returns the pre-clear value). If a wrap and a read land in the same cycle, the bit stays set.
  - 2 INFO: read-only, {CHANNELS[7:0], PERIOD_CNT[23:0]}; writes ignored, no error.
  - 4+ch DUTY[ch]: pending duty, read/write; a read returns the pending value.
  - Any other index: write ignored; read returns 0 with rsp_error=1. Writes never produce a response.
- Read latency: rsp_valid and rsp_data appear exactly one cycle after cmd_valid && !cmd_wr. Back-to-back reads give back-to-back responses.
- Counter:
  - Counts 0..PERIOD_CNT-1 and wraps.
  - Wrap cycle is when the counter == PERIOD_CNT-1; period_tick is registered and high in the cycle where the counter == 0.
  - At wrap, active_duty[ch] <= pending_duty[ch] for all channels simultaneously.
  - A DUTY write in the same cycle as a wrap is captured into pending and takes effect at the next wrap.
- Output: pwm_o[ch] <= CTRL[ch] && (cnt < active_duty[ch]), giving one cycle of latency.
  - Duty 0: constant low.
  - Duty >= PERIOD_CNT: saturates to constant high; compare at full WL width, no truncation.
- Clearing CTRL[ch] forces pwm_o[ch] low on the next cycle, without waiting for a wrap. Setting it resumes output at the current counter phase.

Optional Feature:
- Macro: PWM_BANK_DEADTIME_EN.
- Defined (requires even CHANNELS): channels 2k/2k+1 form a bridge pair.
  - If both raw outputs are high, both are driven low.
  - After either output of a pair falls, the other may not rise for DEADTIME_CYCLES cycles; it is held low and rises once the guard expires, if still requested.
  - A per-pair guard counter resets on resetn.
- Undefined: channels are fully independent, and no guard logic is built.

Decomposition:
- Package pwm_bank_pkg holds:
  - the register-index enum (CTRL_REG=0, STATUS_REG=1, INFO_REG=2, DUTY_BASE_REG=4);
  - the PERIOD_CNT and counter-width localparam helpers.
- Sub-module pwm_bank_channel holds the per-channel pending/active duty registers, the compare, and the enable gating. The top holds the shared counter, the bus decode and, under the macro, the pair guard.

Test Plan (CLK_FREQ=1000, PWM_FREQ=100, so PERIOD_CNT=10; CHANNELS=4):
- Reset mid-period with CTRL=0xF and DUTY0=5: all pwm_o drop to 0 immediately. After release, DUTY read returns 0 and STATUS=0.
- Write DUTY0=3, CTRL=1: no change until the next wrap. Then pwm_o[0] is high 3 cycles, low 7 cycles, repeating.
- DUTY1=0 gives constant low; DUTY1=10 and DUTY1=0xFFFFFFFF each give constant high (CTRL bit1 set).
- Read STATUS after a wrap: returns 1 with rsp_valid one cycle later, and an immediate re-read returns 0. A read coincident with a wrap leaves the bit at 1.
- Read index 3 and index 8: rsp_data=0, rsp_error=1. Read INFO: returns 0x0400000A.
- With PWM_BANK_DEADTIME_EN, DEADTIME_CYCLES=2, DUTY0=10 then a switch to DUTY0=0 and DUTY1=10: pwm_o[1] rises no earlier than 2 cycles after pwm_o[0] falls. pwm_o[0] and pwm_o[1] are never high together.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the pwm_bank peripheral.
// Contents:
//   reg_idx_e        word indices of the register window
//   calc_period_cnt  clock cycles per PWM period
//   calc_cnt_wl      width of the period counter
package pwm_bank_pkg;

  typedef enum logic [7:0] {
    CTRL_REG      = 8'd0,
    STATUS_REG    = 8'd1,
    INFO_REG      = 8'd2,
    DUTY_BASE_REG = 8'd4
  } reg_idx_e;

  function automatic int unsigned calc_period_cnt(input int unsigned clk_freq,
                                                  input int unsigned pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  function automatic int unsigned calc_cnt_wl(input int unsigned period_cnt);
    return (period_cnt <= 2) ? 1 : $clog2(period_cnt);
  endfunction

endpackage

// File: rtl/pwm_bank_io_channel.sv
// One PWM channel: pending/active duty registers, compare and enable gating.
// Ports:
//   clk, resetn  system clock, async active-low reset
//   en_i         channel enable (CTRL bit)
//   wr_i         write strobe for the pending duty
//   wdata_i      duty write data
//   wrap_i       period wrap; pending duty is promoted to active
//   cnt_i        period counter, zero-extended to WL
//   pend_o       pending duty (read back on the bus)
//   pwm_o        registered PWM output
module pwm_bank_channel #(
  parameter int unsigned WL = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic [WL-1:0] wdata_i,
  input  logic          wrap_i,
  input  logic [WL-1:0] cnt_i,
  output logic [WL-1:0] pend_o,
  output logic          pwm_o
);

  logic [WL-1:0] pend_q, pend_d;
  logic [WL-1:0] active_q, active_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    pend_d   = wr_i   ? wdata_i : pend_q;
    // A write landing on the wrap cycle is promoted at the following wrap.
    active_d = wrap_i ? pend_q  : active_q;
    // Full-width compare: any duty >= period saturates to constant high.
    pwm_d    = en_i && (cnt_i < active_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q   <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pend_o = pend_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/pwm_bank_io.sv
// Memory-mapped N-channel PWM bank with its own register file.
// Registers: CTRL (enable mask), STATUS (sticky wrap-seen, clear on read),
// INFO (channel count / period), DUTY[ch] (pending duty, applied at wrap).
// Ports:
//   clk, resetn            system clock, async active-low reset
//   cmd_valid/wr/addr/wdata bus command, always accepted
//   rsp_valid/error/data   read response, one cycle after the read command
//   pwm_o                  PWM outputs
//   period_tick            one-cycle pulse while the counter is 0
// Optional: define PWM_BANK_DEADTIME_EN to add bridge-pair dead-time guards
// on channel pairs 2k/2k+1 (requires even CHANNELS).
module pwm_bank_io
  import pwm_bank_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100000000,
  parameter int unsigned PWM_FREQ        = 500,
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned WL              = 32,
  parameter int unsigned ADDR_WL         = 5,
  parameter int unsigned DEADTIME_CYCLES = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  input  logic                cmd_wr,
  input  logic [ADDR_WL-1:0]  cmd_addr,
  input  logic [WL-1:0]       cmd_wdata,
  output logic                rsp_valid,
  output logic                rsp_error,
  output logic [WL-1:0]       rsp_data,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_tick
);

  localparam int unsigned PERIOD_CNT = calc_period_cnt(CLK_FREQ, PWM_FREQ);
  localparam int unsigned CNT_WL     = calc_cnt_wl(PERIOD_CNT);
  localparam logic [31:0] INFO_VAL   = {8'(CHANNELS), 24'(PERIOD_CNT)};

  logic [CNT_WL-1:0]   cnt_q, cnt_d;
  logic                tick_q;
  logic                status_q, status_d;
  logic [CHANNELS-1:0] ctrl_q, ctrl_d;
  logic                rsp_valid_q, rsp_error_q;
  logic [WL-1:0]       rsp_data_q;

  logic                wrap, rd_en, wr_en;
  logic                sel_ctrl, sel_status;
  logic [CHANNELS-1:0] duty_sel, duty_wr, pwm_raw;
  logic [WL-1:0]       pend [CHANNELS];
  logic [WL-1:0]       cnt_wide;
  logic [WL-1:0]       rd_data;
  logic                rd_err;

  assign rd_en      = cmd_valid && !cmd_wr;
  assign wr_en      = cmd_valid && cmd_wr;
  assign sel_ctrl   = (cmd_addr == ADDR_WL'(CTRL_REG));
  assign sel_status = (cmd_addr == ADDR_WL'(STATUS_REG));
  assign wrap       = (cnt_q == CNT_WL'(PERIOD_CNT - 1));
  assign cnt_wide   = WL'(cnt_q);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    assign duty_sel[ch] = (cmd_addr == ADDR_WL'(int'(DUTY_BASE_REG) + ch));
    assign duty_wr[ch]  = wr_en && duty_sel[ch];

    pwm_bank_channel #(.WL(WL)) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .en_i    (ctrl_q[ch]),
      .wr_i    (duty_wr[ch]),
      .wdata_i (cmd_wdata),
      .wrap_i  (wrap),
      .cnt_i   (cnt_wide),
      .pend_o  (pend[ch]),
      .pwm_o   (pwm_raw[ch])
    );
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (sel_ctrl)                               rd_data = WL'(ctrl_q);
    else if (sel_status)                        rd_data = WL'(status_q);
    else if (cmd_addr == ADDR_WL'(INFO_REG))    rd_data = WL'(INFO_VAL);
    else if (|duty_sel) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (duty_sel[i]) rd_data = pend[i];
      end
    end else                                    rd_err  = 1'b1;
  end

  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CNT_WL'(1);
    ctrl_d   = (wr_en && sel_ctrl) ? cmd_wdata[CHANNELS-1:0] : ctrl_q;
    status_d = status_q;
    if (rd_en && sel_status) status_d = 1'b0;
    // A wrap coinciding with the clearing read wins.
    if (wrap)                status_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      status_q    <= 1'b0;
      ctrl_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= wrap;
      status_q    <= status_d;
      ctrl_q      <= ctrl_d;
      rsp_valid_q <= rd_en;
      rsp_error_q <= rd_en && rd_err;
      rsp_data_q  <= rd_en ? rd_data : '0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_data    = rsp_data_q;
  assign period_tick = tick_q;

`ifdef PWM_BANK_DEADTIME_EN
  localparam int unsigned GUARD_WL =
    (DEADTIME_CYCLES < 1) ? 1 : $clog2(DEADTIME_CYCLES + 1);

  for (genvar p = 0; p < CHANNELS / 2; p++) begin : g_pair
    logic [GUARD_WL-1:0] guard_q, guard_d;
    logic                blk_b_q, blk_b_d;  // 1: odd channel is being held off
    logic                out_a_q, out_b_q;
    logic                req_a, req_b, nxt_a, nxt_b, hold_a, hold_b;

    always_comb begin
      // Both requested high is a shoot-through request: drive both low.
      req_a   = pwm_raw[2*p]   && !pwm_raw[2*p+1];
      req_b   = pwm_raw[2*p+1] && !pwm_raw[2*p];
      hold_a  = (guard_q != '0) && !blk_b_q;
      hold_b  = (guard_q != '0) &&  blk_b_q;
      nxt_a   = req_a && (out_a_q || (!out_b_q && !hold_a));
      nxt_b   = req_b && (out_b_q || (!out_a_q && !hold_b));
      guard_d = (guard_q != '0) ? guard_q - GUARD_WL'(1) : '0;
      blk_b_d = blk_b_q;
      if (out_a_q && !nxt_a) begin
        guard_d = GUARD_WL'(DEADTIME_CYCLES);
        blk_b_d = 1'b1;
      end else if (out_b_q && !nxt_b) begin
        guard_d = GUARD_WL'(DEADTIME_CYCLES);
        blk_b_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        guard_q <= '0;
        blk_b_q <= 1'b0;
        out_a_q <= 1'b0;
        out_b_q <= 1'b0;
      end else begin
        guard_q <= guard_d;
        blk_b_q <= blk_b_d;
        out_a_q <= nxt_a;
        out_b_q <= nxt_b;
      end
    end

    assign pwm_o[2*p]   = out_a_q;
    assign pwm_o[2*p+1] = out_b_q;
  end
`else
  logic unused_deadtime;
  assign unused_deadtime = ^DEADTIME_CYCLES;
  assign pwm_o = pwm_raw;
`endif

endmodule

// File: tb/tb_pwm_bank_io.sv
module tb_pwm_bank_io;

  localparam int CH = 4;
`ifdef PWM_BANK_DEADTIME_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_wr;
  logic [4:0]    cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_error;
  logic [31:0]   rsp_data;
  logic [CH-1:0] pwm_o;
  logic          period_tick;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_bank_io #(
    .CLK_FREQ        (1000),
    .PWM_FREQ        (100),
    .CHANNELS        (CH),
    .WL              (32),
    .ADDR_WL         (5),
    .DEADTIME_CYCLES (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_error   (rsp_error),
    .rsp_data    (rsp_data),
    .pwm_o       (pwm_o),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          ch;
    logic [31:0] duty;
    logic [3:0]  ctrl;
    logic [9:0]  pat;   // bit j = expected output while counter == j
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step();
      if (period_tick) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: got no period_tick, expected one within 15 cycles");
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d,
                          output logic e, output logic v);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = a;
    step();
    d = rsp_data;
    e = rsp_error;
    v = rsp_valid;
    cmd_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] a,
                            input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic e, v;
    bus_read(a, d, e, v);
    check({name, "_valid"}, 32'(v), 32'd1);
    check({name, "_data"},  d, exp_d);
    check({name, "_error"}, 32'(e), 32'(exp_e));
  endtask

  // Entered on the sample where period_tick is high (counter == 0).
  task automatic check_pattern(input string name, input int ch, input logic [9:0] pat0,
                               input logic [9:0] pat1, input int nper);
    logic [9:0] pat;
    repeat (LAT - 1) step();
    for (int p = 0; p < nper; p++) begin
      pat = (p == 0) ? pat0 : pat1;
      for (int j = 0; j < 10; j++) begin
        step();
        check(name, 32'(pwm_o), pat[j] ? (32'd1 << ch) : 32'd0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{ch: 1, duty: 32'd0,          ctrl: 4'b0010, pat: 10'h000};
    vecs[1] = '{ch: 1, duty: 32'd10,         ctrl: 4'b0010, pat: 10'h3FF};
    vecs[2] = '{ch: 1, duty: 32'hFFFF_FFFF,  ctrl: 4'b0010, pat: 10'h3FF};
    vecs[3] = '{ch: 1, duty: 32'd9,          ctrl: 4'b0010, pat: 10'h1FF};
    vecs[4] = '{ch: 2, duty: 32'd1,          ctrl: 4'b0100, pat: 10'h001};
    vecs[5] = '{ch: 3, duty: 32'd5,          ctrl: 4'b0000, pat: 10'h000};
    vecs[6] = '{ch: 0, duty: 32'd11,         ctrl: 4'b0001, pat: 10'h3FF};

    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) step();
    check("rst_pwm",   32'(pwm_o), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_tick",  32'(period_tick), 32'd0);
    check("rst_data",  rsp_data, 32'd0);
    resetn = 1'b1;

    // Reset in the middle of a period with outputs active.
    bus_write(5'd0, 32'hF);
    bus_write(5'd4, 32'd5);
    wait_tick();
    repeat (LAT + 1) step();
    check("pre_rst_pwm", 32'(pwm_o), 32'h1);
    resetn = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_o), 32'd0);
    step();
    resetn = 1'b1;
    read_check("rst_duty0",  5'd4, 32'd0, 1'b0);
    read_check("rst_status", 5'd1, 32'd0, 1'b0);
    read_check("rst_ctrl",   5'd0, 32'd0, 1'b0);

    // Duty 3 on channel 0: nothing until the wrap, then 3 high / 7 low.
    begin
      bit seen = 1'b0;
      wait_tick();
      bus_write(5'd4, 32'd3);
      bus_write(5'd0, 32'd1);
      for (int i = 0; i < 15 && !seen; i++) begin
        step();
        if (period_tick) seen = 1'b1;
        else check("hold_until_wrap", 32'(pwm_o), 32'd0);
      end
      check("hold_wrap_seen", 32'(seen), 32'd1);
      check_pattern("duty3", 0, 10'h007, 10'h007, 2);
    end

    // DUTY write on the wrap cycle takes effect one period later.
    wait_tick();
    repeat (9) step();
    bus_write(5'd4, 32'd6);
    check("coincide_tick", 32'(period_tick), 32'd1);
    check_pattern("duty_wrap_write", 0, 10'h007, 10'h03F, 2);

    // Enable gating acts immediately and resumes at the current phase.
    bus_write(5'd4, 32'd9);
    wait_tick();
    repeat (LAT + 1) step();
    bus_write(5'd0, 32'd0);
    check("dis_pre", 32'(pwm_o), 32'h1);
    repeat (LAT) step();
    check("dis", 32'(pwm_o), 32'h0);
    bus_write(5'd0, 32'd1);
    check("en_pre", 32'(pwm_o), 32'h0);
    repeat (LAT) step();
    check("resume", 32'(pwm_o), 32'h1);
    repeat (9 - (2 * LAT + 3)) step();
    check("resume_phase", 32'(pwm_o), 32'h0);

    // Table of duty/enable vectors, one full period each.
    for (int v = 0; v < 7; v++) begin
      wait_tick();
      bus_write(5'(4 + vecs[v].ch), vecs[v].duty);
      bus_write(5'd0, 32'(vecs[v].ctrl));
      wait_tick();
      check_pattern($sformatf("vec%0d", v), vecs[v].ch, vecs[v].pat, vecs[v].pat, 1);
    end

    // STATUS: sticky, clear on read, wrap wins over a coincident read.
    wait_tick();
    check("rsp_idle", 32'(rsp_valid), 32'd0);
    read_check("status_set",   5'd1, 32'd1, 1'b0);
    read_check("status_clr",   5'd1, 32'd0, 1'b0);
    repeat (7) step();
    read_check("status_coinc", 5'd1, 32'd0, 1'b0);
    check("status_coinc_tick", 32'(period_tick), 32'd1);
    read_check("status_kept",  5'd1, 32'd1, 1'b0);

    // Register map edges.
    read_check("unmapped3", 5'd3, 32'd0, 1'b0 ^ 1'b1);
    read_check("unmapped8", 5'd8, 32'd0, 1'b1);
    read_check("info",      5'd2, 32'h0400_000A, 1'b0);
    bus_write(5'd2, 32'h5);
    check("wr_info_no_rsp", 32'(rsp_valid), 32'd0);
    bus_write(5'd9, 32'h5);
    check("wr_unmapped_no_rsp", 32'(rsp_valid), 32'd0);
    read_check("info_after_wr", 5'd2, 32'h0400_000A, 1'b0);
    bus_write(5'd0, 32'hFFFF_FFFF);
    read_check("ctrl_mask", 5'd0, 32'h0000_000F, 1'b0);
    read_check("duty2_rb",  5'd6, 32'd1, 1'b0);

`ifdef PWM_BANK_DEADTIME_EN
    begin
      int fall_at = -1;
      int rise_at = -1;
      logic p0_prev, p1_prev;
      bus_write(5'd0, 32'h3);
      bus_write(5'd4, 32'd10);
      bus_write(5'd5, 32'd0);
      wait_tick();
      wait_tick();
      repeat (LAT) step();
      check("dt_pre_high", 32'(pwm_o[1:0]), 32'h1);
      bus_write(5'd4, 32'd0);
      bus_write(5'd5, 32'd10);
      p0_prev = pwm_o[0];
      p1_prev = pwm_o[1];
      for (int i = 0; i < 30; i++) begin
        step();
        check("dt_overlap", 32'(pwm_o[0] & pwm_o[1]), 32'd0);
        if (p0_prev && !pwm_o[0] && fall_at < 0) fall_at = i;
        if (!p1_prev && pwm_o[1] && rise_at < 0) rise_at = i;
        p0_prev = pwm_o[0];
        p1_prev = pwm_o[1];
      end
      check("dt_fall_seen", 32'(fall_at >= 0), 32'd1);
      check("dt_rise_seen", 32'(rise_at >= 0), 32'd1);
      check("dt_gap", 32'((rise_at - fall_at) >= 2), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
